// File: rtl/img_cap_pkg.sv
// Types and constants shared across the image-capture memory path
// (frame_buf_alt, ram_int_4p, avl_port_arb).
package img_cap_pkg;

  localparam int unsigned DefAddrW = 29;
  localparam int unsigned DefDataW = 32;

  typedef enum logic [1:0] {
    StIdle,
    StGRd,
    StGW0,
    StGW1
  } arb_state_e;

  // Master IDs as reported on gnt_id and kept in last_id.
  localparam logic [1:0] IdNone = 2'd0;
  localparam logic [1:0] IdRd   = 2'd1;
  localparam logic [1:0] IdW0   = 2'd2;
  localparam logic [1:0] IdW1   = 2'd3;

endpackage

// File: rtl/arb_rr3.sv
// Combinational 3-way round-robin picker (bit 0 = RD, 1 = W0, 2 = W1) with an
// urgent override that hands the port to RD.
module arb_rr3
  import img_cap_pkg::*;
(
  input  logic [2:0] req_i,
  input  logic [1:0] last_id_i,
  input  logic       urgent_i,
  output logic [2:0] gnt_o
);

  logic [1:0] start;
  logic [5:0] req_dbl;
  logic [2:0] req_rot;
  logic [2:0] gnt_rot;
  logic [5:0] gnt_dbl;

  // Priority starts at the requester after the last owner.
  always_comb begin
    unique case (last_id_i)
      IdRd:    start = 2'd1;
      IdW0:    start = 2'd2;
      default: start = 2'd0;
    endcase
  end

  // Rotate so the top-priority requester sits at bit 0, isolate the lowest set
  // bit, then rotate the grant back.
  always_comb begin
    req_dbl = {req_i, req_i} >> start;
    req_rot = req_dbl[2:0];
    gnt_rot = req_rot & (~req_rot + 3'd1);
    gnt_dbl = {gnt_rot, gnt_rot} << start;
    if (urgent_i && req_i[0]) begin
      gnt_o = 3'b001;
    end else begin
      gnt_o = gnt_dbl[5:3];
    end
  end

endmodule

// File: rtl/avl_port_arb.sv
// Burst-granular round-robin arbiter sharing one Avalon-MM port between the
// display read path and the two camera write paths, with read throttling.
module avl_port_arb
  import img_cap_pkg::*;
#(
  parameter int unsigned ADDR_W     = DefAddrW,
  parameter int unsigned DATA_W     = DefDataW,
  parameter int unsigned BURST_LEN  = 16,
  parameter int unsigned MAX_RD_OUT = 8
) (
  input  logic              clk_25_2m,
  input  logic              reset,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic              rd_urgent,
  output logic              rd_ack,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  input  logic [1:0]        wr_req,
  input  logic [ADDR_W-1:0] wr_addr0,
  input  logic [ADDR_W-1:0] wr_addr1,
  input  logic [DATA_W-1:0] wr_data0,
  input  logic [DATA_W-1:0] wr_data1,
  output logic [1:0]        wr_ack,
  input  logic              avl_ready,
  input  logic [DATA_W-1:0] avl_rdata,
  input  logic              avl_rdata_valid,
  output logic              avl_read_req,
  output logic              avl_write_req,
  output logic [ADDR_W-1:0] avl_addr,
  output logic [DATA_W-1:0] avl_wdata,
  input  logic              ram_rdy,
  output logic [1:0]        gnt_id,
  output logic              err_rd_underflow
);

  localparam int unsigned BcW = $clog2(BURST_LEN + 1);
  localparam int unsigned RoW = $clog2(MAX_RD_OUT + 1);
  localparam logic [BcW-1:0] BeatLast = BcW'(BURST_LEN - 1);
  localparam logic [RoW-1:0] RdOutMax = RoW'(MAX_RD_OUT);

  arb_state_e        state_q, state_d;
  logic [1:0]        last_id_q, last_id_d;
  logic [BcW-1:0]    beat_cnt_q, beat_cnt_d;
  logic [RoW-1:0]    rd_out_q, rd_out_d;
  logic              err_q, err_d;
  logic              rd_valid_q;
  logic [DATA_W-1:0] rd_data_q;

  logic [2:0] req_vec;
  logic [2:0] win;
  logic       rd_stb, w0_stb, w1_stb;
  logic       beat;
  logic       owner_req;
  logic [1:0] owner_id;
  logic       preempt;

  assign req_vec = {wr_req[1], wr_req[0], rd_req};

  arb_rr3 u_arb_rr3 (
    .req_i     (req_vec),
    .last_id_i (last_id_q),
    .urgent_i  (rd_urgent),
    .gnt_o     (win)
  );

  // Strobes drop as soon as calibration is lost; avl_ready is low then anyway.
  assign rd_stb = (state_q == StGRd) && rd_req && ram_rdy && (rd_out_q < RdOutMax);
  assign w0_stb = (state_q == StGW0) && wr_req[0] && ram_rdy;
  assign w1_stb = (state_q == StGW1) && wr_req[1] && ram_rdy;

  assign avl_read_req  = rd_stb;
  assign avl_write_req = w0_stb | w1_stb;
  assign rd_ack        = rd_stb & avl_ready;
  assign wr_ack        = {w1_stb & avl_ready, w0_stb & avl_ready};
  assign beat          = rd_ack | wr_ack[0] | wr_ack[1];

  always_comb begin
    owner_req = 1'b0;
    owner_id  = IdNone;
    avl_addr  = '0;
    avl_wdata = '0;
    unique case (state_q)
      StGRd: begin
        owner_req = rd_req;
        owner_id  = IdRd;
        avl_addr  = rd_addr;
      end
      StGW0: begin
        owner_req = wr_req[0];
        owner_id  = IdW0;
        avl_addr  = wr_addr0;
        avl_wdata = wr_data0;
      end
      StGW1: begin
        owner_req = wr_req[1];
        owner_id  = IdW1;
        avl_addr  = wr_addr1;
        avl_wdata = wr_data1;
      end
      default: ;
    endcase
  end

  assign gnt_id = owner_id;

  always_comb begin
    state_d    = state_q;
    last_id_d  = last_id_q;
    beat_cnt_d = beat_cnt_q;
    preempt    = 1'b0;
    if (state_q == StIdle) begin
      beat_cnt_d = '0;
      if (ram_rdy) begin
        if (win[0]) begin
          state_d = StGRd;
        end else if (win[1]) begin
          state_d = StGW0;
        end else if (win[2]) begin
          state_d = StGW1;
        end
      end
    end else begin
      if (beat) begin
        beat_cnt_d = beat_cnt_q + BcW'(1);
      end
      // An urgent display request only cuts a write grant at a beat boundary.
      preempt = (state_q != StGRd) && rd_urgent && rd_req;
      if (!ram_rdy || !owner_req || (beat && ((beat_cnt_q == BeatLast) || preempt))) begin
        state_d    = StIdle;
        last_id_d  = owner_id;
        beat_cnt_d = '0;
      end
    end
  end

  always_comb begin
    rd_out_d = rd_out_q;
    err_d    = err_q;
    if (rd_ack && !avl_rdata_valid) begin
      rd_out_d = rd_out_q + RoW'(1);
    end else if (!rd_ack && avl_rdata_valid) begin
      if (rd_out_q == '0) begin
        err_d = 1'b1;
      end else begin
        rd_out_d = rd_out_q - RoW'(1);
      end
    end
  end

  always_ff @(posedge clk_25_2m) begin
    if (!reset) begin
      state_q    <= StIdle;
      last_id_q  <= IdW1;
      beat_cnt_q <= '0;
      rd_out_q   <= '0;
      err_q      <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      last_id_q  <= last_id_d;
      beat_cnt_q <= beat_cnt_d;
      rd_out_q   <= rd_out_d;
      err_q      <= err_d;
      rd_valid_q <= avl_rdata_valid;
      rd_data_q  <= avl_rdata;
    end
  end

  assign rd_valid         = rd_valid_q;
  assign rd_data          = rd_data_q;
  assign err_rd_underflow = err_q;

endmodule

// File: tb/tb_avl_port_arb.sv
// Self-checking bench for avl_port_arb: directed scenarios plus a randomized run
// against a behavioural model of the arbitration rules.
module tb_avl_port_arb;

  localparam int unsigned AddrW    = 29;
  localparam int unsigned DataW    = 32;
  localparam int          BurstLen = 16;
  localparam int          MaxRdOut = 8;

  logic             clk_25_2m = 1'b0;
  logic             reset = 1'b0;
  logic             rd_req, rd_urgent, rd_ack, rd_valid;
  logic [AddrW-1:0] rd_addr, wr_addr0, wr_addr1, avl_addr;
  logic [DataW-1:0] rd_data, wr_data0, wr_data1, avl_rdata, avl_wdata;
  logic [1:0]       wr_req, wr_ack, gnt_id;
  logic             avl_ready, avl_rdata_valid, avl_read_req, avl_write_req;
  logic             ram_rdy, err_rd_underflow;

  int checks = 0;
  int errors = 0;

  always #5 clk_25_2m = ~clk_25_2m;

  avl_port_arb #(
    .ADDR_W     (AddrW),
    .DATA_W     (DataW),
    .BURST_LEN  (BurstLen),
    .MAX_RD_OUT (MaxRdOut)
  ) dut (
    .clk_25_2m        (clk_25_2m),
    .reset            (reset),
    .rd_req           (rd_req),
    .rd_addr          (rd_addr),
    .rd_urgent        (rd_urgent),
    .rd_ack           (rd_ack),
    .rd_valid         (rd_valid),
    .rd_data          (rd_data),
    .wr_req           (wr_req),
    .wr_addr0         (wr_addr0),
    .wr_addr1         (wr_addr1),
    .wr_data0         (wr_data0),
    .wr_data1         (wr_data1),
    .wr_ack           (wr_ack),
    .avl_ready        (avl_ready),
    .avl_rdata        (avl_rdata),
    .avl_rdata_valid  (avl_rdata_valid),
    .avl_read_req     (avl_read_req),
    .avl_write_req    (avl_write_req),
    .avl_addr         (avl_addr),
    .avl_wdata        (avl_wdata),
    .ram_rdy          (ram_rdy),
    .gnt_id           (gnt_id),
    .err_rd_underflow (err_rd_underflow)
  );

  // Behavioural model: owner 0 = none, 1 = RD, 2 = W0, 3 = W1.
  int               m_owner, m_last, m_beats, m_out;
  bit               m_err, m_rv;
  logic [DataW-1:0] m_rdata;
  logic [1:0]       e_gnt;
  bit               e_rd_stb, e_w0_stb, e_w1_stb, e_rd_ack, e_w0_ack, e_w1_ack;
  logic [AddrW-1:0] e_addr;
  logic [DataW-1:0] e_wdata;

  function automatic bit requested(int id);
    case (id)
      1:       return rd_req;
      2:       return wr_req[0];
      3:       return wr_req[1];
      default: return 1'b0;
    endcase
  endfunction

  function automatic void model_reset();
    m_owner = 0;
    m_last  = 3;
    m_beats = 0;
    m_out   = 0;
    m_err   = 1'b0;
    m_rv    = 1'b0;
    m_rdata = '0;
  endfunction

  function automatic void model_expect();
    e_gnt    = 2'(m_owner);
    e_rd_stb = (m_owner == 1) && rd_req && ram_rdy && (m_out < MaxRdOut);
    e_w0_stb = (m_owner == 2) && wr_req[0] && ram_rdy;
    e_w1_stb = (m_owner == 3) && wr_req[1] && ram_rdy;
    e_rd_ack = e_rd_stb && avl_ready;
    e_w0_ack = e_w0_stb && avl_ready;
    e_w1_ack = e_w1_stb && avl_ready;
    e_addr   = '0;
    e_wdata  = '0;
    case (m_owner)
      1: e_addr = rd_addr;
      2: begin e_addr = wr_addr0; e_wdata = wr_data0; end
      3: begin e_addr = wr_addr1; e_wdata = wr_data1; end
      default: ;
    endcase
  endfunction

  function automatic void model_step();
    int nxt;
    bit beat;
    bit cut;
    beat = e_rd_ack || e_w0_ack || e_w1_ack;
    if (e_rd_ack && !avl_rdata_valid) m_out++;
    else if (!e_rd_ack && avl_rdata_valid) begin
      if (m_out == 0) m_err = 1'b1;
      else m_out--;
    end
    m_rv    = avl_rdata_valid;
    m_rdata = avl_rdata;
    if (m_owner == 0) begin
      m_beats = 0;
      if (ram_rdy) begin
        if (rd_urgent && rd_req) m_owner = 1;
        else begin
          for (int k = 1; k <= 3; k++) begin
            nxt = (m_last + k - 1) % 3 + 1;
            if (m_owner == 0 && requested(nxt)) m_owner = nxt;
          end
        end
      end
    end else begin
      if (beat) m_beats++;
      cut = beat && (m_beats == BurstLen || (m_owner != 1 && rd_urgent && rd_req));
      if (!ram_rdy || !requested(m_owner) || cut) begin
        m_last  = m_owner;
        m_owner = 0;
        m_beats = 0;
      end
    end
  endfunction

  task automatic clear_inputs();
    rd_req          = 1'b0;
    rd_urgent       = 1'b0;
    rd_addr         = '0;
    wr_req          = 2'b00;
    wr_addr0        = '0;
    wr_addr1        = '0;
    wr_data0        = '0;
    wr_data1        = '0;
    avl_ready       = 1'b0;
    avl_rdata       = '0;
    avl_rdata_valid = 1'b0;
    ram_rdy         = 1'b1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    repeat (3) @(posedge clk_25_2m);
    #1;
    reset = 1'b1;
  endtask

  task automatic test_reset();
    clear_inputs();
    rd_req    = 1'b1;
    avl_ready = 1'b1;
    rd_addr   = 29'h55;
    avl_rdata = 32'hDEAD_BEEF;
    reset     = 1'b0;
    repeat (2) @(posedge clk_25_2m);
    #1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk_25_2m);
      checks++;
      if ({avl_read_req, avl_write_req, rd_ack, wr_ack, gnt_id, rd_valid, err_rd_underflow,
           avl_addr, avl_wdata, rd_data} !== '0) begin
        errors++;
        $display("FAIL reset_outputs cyc %0d got gnt=%0d rreq=%b wreq=%b addr=%h rdata=%h exp all 0",
                 c, gnt_id, avl_read_req, avl_write_req, avl_addr, rd_data);
      end
      @(posedge clk_25_2m);
      #1;
    end
    reset = 1'b1;
    @(negedge clk_25_2m);
    checks++;
    if (avl_read_req !== 1'b0 || gnt_id !== 2'd0) begin
      errors++;
      $display("FAIL reset_release_idle got rreq=%b gnt=%0d exp rreq=0 gnt=0", avl_read_req, gnt_id);
    end
    @(posedge clk_25_2m);
    #1;
    @(negedge clk_25_2m);
    checks++;
    if (avl_read_req !== 1'b1 || gnt_id !== 2'd1 || rd_ack !== 1'b1 || avl_addr !== 29'h55) begin
      errors++;
      $display("FAIL reset_first_grant got rreq=%b gnt=%0d ack=%b addr=%h exp 1 1 1 55",
               avl_read_req, gnt_id, rd_ack, avl_addr);
    end
  endtask

  task automatic test_round_robin();
    int g;
    bit got_ack;
    logic [AddrW-1:0] ea;
    clear_inputs();
    rd_req          = 1'b1;
    wr_req          = 2'b11;
    avl_ready       = 1'b1;
    avl_rdata_valid = 1'b1;  // keeps the outstanding count at zero
    rd_addr         = 29'h100;
    wr_addr0        = 29'h200;
    wr_addr1        = 29'h300;
    do_reset();
    for (int c = 0; c < 68; c++) begin
      @(negedge clk_25_2m);
      g = (c % 17 == 0) ? 0 : (c / 17) % 3 + 1;
      case (g)
        1:       begin got_ack = rd_ack;    ea = 29'h100; end
        2:       begin got_ack = wr_ack[0]; ea = 29'h200; end
        3:       begin got_ack = wr_ack[1]; ea = 29'h300; end
        default: begin got_ack = rd_ack | wr_ack[0] | wr_ack[1]; ea = '0; end
      endcase
      checks++;
      if (gnt_id !== 2'(g) || got_ack !== (g != 0) || avl_addr !== ea) begin
        errors++;
        $display("FAIL rr_sequence cyc %0d got gnt=%0d ack=%b addr=%h exp gnt=%0d ack=%b addr=%h",
                 c, gnt_id, got_ack, avl_addr, g, (g != 0), ea);
      end
      @(posedge clk_25_2m);
      #1;
    end
  endtask

  task automatic test_urgent_preempt();
    int acks = 0;
    bit armed = 1'b0;
    clear_inputs();
    wr_req    = 2'b01;
    avl_ready = 1'b1;
    do_reset();
    for (int c = 0; c < 12; c++) begin
      @(negedge clk_25_2m);
      if (wr_ack[0] === 1'b1) acks++;
      if (c == 7) begin
        checks++;
        if (gnt_id !== 2'd0) begin
          errors++;
          $display("FAIL preempt_bubble got gnt=%0d exp 0", gnt_id);
        end
      end
      if (c == 8) begin
        checks++;
        if (gnt_id !== 2'd1 || rd_ack !== 1'b1) begin
          errors++;
          $display("FAIL preempt_rd_grant got gnt=%0d ack=%b exp gnt=1 ack=1", gnt_id, rd_ack);
        end
      end
      @(posedge clk_25_2m);
      #1;
      if (acks == 5 && !armed) begin
        rd_req    = 1'b1;
        rd_urgent = 1'b1;
        armed     = 1'b1;
      end
    end
    checks++;
    if (acks != 6) begin
      errors++;
      $display("FAIL preempt_w0_acks got %0d exp 6", acks);
    end
  endtask

  task automatic test_stall();
    int acks = 0;
    bit got;
    logic [AddrW-1:0] base_a;
    logic [DataW-1:0] base_d;
    clear_inputs();
    base_a   = 29'h0ABC_DE0;
    base_d   = 32'h1234_5678;
    wr_addr1 = base_a;
    wr_data1 = base_d;
    do_reset();
    for (int c = 0; c < 8; c++) begin
      avl_ready = !(c == 2 || c == 3);
      wr_req    = (acks < 2) ? 2'b10 : 2'b00;
      @(negedge clk_25_2m);
      got = (wr_ack[1] === 1'b1);
      if (c >= 2 && c <= 4) begin
        checks++;
        if (avl_write_req !== 1'b1 || avl_addr !== base_a + 29'd1 ||
            avl_wdata !== base_d + 32'h0101_0101) begin
          errors++;
          $display("FAIL stall_hold cyc %0d got wreq=%b addr=%h data=%h exp 1 %h %h", c,
                   avl_write_req, avl_addr, avl_wdata, base_a + 29'd1, base_d + 32'h0101_0101);
        end
      end
      if (got) acks++;
      @(posedge clk_25_2m);
      #1;
      if (got) begin
        wr_addr1 = wr_addr1 + 29'd1;
        wr_data1 = wr_data1 + 32'h0101_0101;
      end
    end
    checks++;
    if (acks != 2) begin
      errors++;
      $display("FAIL stall_acks got %0d exp 2", acks);
    end
  endtask

  task automatic test_rd_throttle();
    int stb = 0;
    clear_inputs();
    rd_req    = 1'b1;
    avl_ready = 1'b1;
    do_reset();
    for (int c = 0; c < 14; c++) begin
      @(negedge clk_25_2m);
      if (avl_read_req === 1'b1) stb++;
      if (c == 13) begin
        checks++;
        if (avl_read_req !== 1'b0 || gnt_id !== 2'd1) begin
          errors++;
          $display("FAIL throttle_stop got rreq=%b gnt=%0d exp 0 1", avl_read_req, gnt_id);
        end
      end
      @(posedge clk_25_2m);
      #1;
    end
    checks++;
    if (stb != MaxRdOut) begin
      errors++;
      $display("FAIL throttle_count got %0d exp %0d", stb, MaxRdOut);
    end
    avl_rdata_valid = 1'b1;
    avl_rdata       = 32'hA5A5_0001;
    stb = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk_25_2m);
      if (avl_read_req === 1'b1) stb++;
      if (c == 1) begin
        checks++;
        if (rd_valid !== 1'b1 || rd_data !== 32'hA5A5_0001) begin
          errors++;
          $display("FAIL throttle_return got valid=%b data=%h exp 1 a5a50001", rd_valid, rd_data);
        end
      end
      @(posedge clk_25_2m);
      #1;
      avl_rdata_valid = 1'b0;
    end
    checks++;
    if (stb != 1 || err_rd_underflow !== 1'b0) begin
      errors++;
      $display("FAIL throttle_resume got strobes=%0d err=%b exp 1 0", stb, err_rd_underflow);
    end
  endtask

  task automatic test_underflow();
    int stb = 0;
    clear_inputs();
    do_reset();
    avl_rdata_valid = 1'b1;
    @(negedge clk_25_2m);
    checks++;
    if (err_rd_underflow !== 1'b0) begin
      errors++;
      $display("FAIL underflow_before got %b exp 0", err_rd_underflow);
    end
    @(posedge clk_25_2m);
    #1;
    avl_rdata_valid = 1'b0;
    rd_req          = 1'b1;
    avl_ready       = 1'b1;
    for (int c = 0; c < 14; c++) begin
      @(negedge clk_25_2m);
      if (avl_read_req === 1'b1) stb++;
      checks++;
      if (err_rd_underflow !== 1'b1) begin
        errors++;
        $display("FAIL underflow_sticky cyc %0d got %b exp 1", c, err_rd_underflow);
      end
      @(posedge clk_25_2m);
      #1;
    end
    checks++;
    if (stb != MaxRdOut) begin
      errors++;
      $display("FAIL underflow_counter got strobes=%0d exp %0d", stb, MaxRdOut);
    end
    clear_inputs();
    do_reset();
    @(negedge clk_25_2m);
    checks++;
    if (err_rd_underflow !== 1'b0) begin
      errors++;
      $display("FAIL underflow_cleared got %b exp 0", err_rd_underflow);
    end
  endtask

  task automatic test_random();
    clear_inputs();
    do_reset();
    model_reset();
    for (int c = 0; c < 1500; c++) begin
      rd_req          = ($urandom_range(0, 3) != 0);
      wr_req          = 2'($urandom_range(0, 3));
      rd_urgent       = ($urandom_range(0, 7) == 0);
      avl_ready       = ($urandom_range(0, 3) != 0);
      ram_rdy         = ($urandom_range(0, 29) != 0);
      rd_addr         = 29'($urandom);
      wr_addr0        = 29'($urandom);
      wr_addr1        = 29'($urandom);
      wr_data0        = $urandom;
      wr_data1        = $urandom;
      avl_rdata       = $urandom;
      avl_rdata_valid = (m_out > 0) && ($urandom_range(0, 2) == 0);
      @(negedge clk_25_2m);
      model_expect();
      checks++;
      if ({gnt_id, avl_read_req, avl_write_req, rd_ack, wr_ack} !==
          {e_gnt, e_rd_stb, e_w0_stb | e_w1_stb, e_rd_ack, e_w1_ack, e_w0_ack}) begin
        errors++;
        $display("FAIL rnd_ctrl cyc %0d got gnt=%0d rreq=%b wreq=%b rack=%b wack=%b exp %0d %b %b %b %b%b",
                 c, gnt_id, avl_read_req, avl_write_req, rd_ack, wr_ack, e_gnt, e_rd_stb,
                 e_w0_stb | e_w1_stb, e_rd_ack, e_w1_ack, e_w0_ack);
      end
      checks++;
      if (avl_addr !== e_addr || avl_wdata !== e_wdata) begin
        errors++;
        $display("FAIL rnd_mux cyc %0d got addr=%h data=%h exp addr=%h data=%h",
                 c, avl_addr, avl_wdata, e_addr, e_wdata);
      end
      checks++;
      if (rd_valid !== m_rv || rd_data !== m_rdata || err_rd_underflow !== m_err) begin
        errors++;
        $display("FAIL rnd_return cyc %0d got v=%b d=%h err=%b exp v=%b d=%h err=%b",
                 c, rd_valid, rd_data, err_rd_underflow, m_rv, m_rdata, m_err);
      end
      model_step();
      @(posedge clk_25_2m);
      #1;
    end
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_round_robin();
    test_urgent_preempt();
    test_stall();
    test_rd_throttle();
    test_underflow();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
